seg_scan_decoder: RTL and testbench

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

---
 rtl/seg_scan_decoder.sv | 214 +++++++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// Multiplexed 7-segment scan decoder: recovers the hex digits behind three active-low anodes.
// Optional overrun detection is built only when SEG_SCAN_OVERRUN_EN is defined.
module seg_scan_decoder #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       AN0,
    input  logic       AN1,
    input  logic       AN2,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    input  logic       e,
    input  logic       fp,
    input  logic       g,
    input  logic       dp,
    input  logic       frame_ack,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [2:0] dp_flags,
    output logic [2:0] digit_err,
    output logic       frame_valid,
    output logic       overrun
);

    typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, HELD = 2'd2} state_t;

    // Returns {err, value}; unknown patterns decode to value 0 with err set.
    function automatic logic [4:0] decode_seg(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'h7E: r = 5'h00;
            7'h30: r = 5'h01;
            7'h6D: r = 5'h02;
            7'h79: r = 5'h03;
            7'h33: r = 5'h04;
            7'h5B: r = 5'h05;
            7'h5F: r = 5'h06;
            7'h70: r = 5'h07;
            7'h7F: r = 5'h08;
            7'h7B: r = 5'h09;
            7'h77: r = 5'h0A;
            7'h1F: r = 5'h0B;
            7'h4E: r = 5'h0C;
            7'h3D: r = 5'h0D;
            7'h4F: r = 5'h0E;
            7'h47: r = 5'h0F;
            default: r = 5'h10;
        endcase
        return r;
    endfunction

    logic [10:0]      sync1_q, sync2_q, prev_q;
    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [2:0]       seen_q, seen_d;
    logic [2:0][3:0]  digit_q, digit_d;
    logic [2:0]       dp_q, dp_d;
    logic [2:0]       err_q, err_d;
    logic             fv_q, fv_d;

    logic [2:0]       sel_s;
    logic [6:0]       seg_s;
    logic             dp_low_s;
    logic             active_s;
    logic             same_s;
    logic             capture_s;
    logic             frame_done_s;
    logic [4:0]       dec_s;

    // Sample layout: {AN2, AN1, AN0, a..g, dp}, all active-low at the pins.
    assign sel_s        = ~sync2_q[10:8];
    assign seg_s        = ~sync2_q[7:1];
    assign dp_low_s     = ~sync2_q[0];
    assign active_s     = (sel_s == 3'b001) || (sel_s == 3'b010) || (sel_s == 3'b100);
    assign same_s       = (sync2_q == prev_q);
    assign dec_s        = decode_seg(seg_s);
    assign frame_done_s = (seen_q == 3'b111);

    // Input synchronizer and previous-sample register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= 11'h7FF;
            sync2_q <= 11'h7FF;
            prev_q  <= 11'h7FF;
        end else begin
            sync1_q <= {AN2, AN1, AN0, a, b, c, d, e, fp, g, dp};
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Settle FSM: a capture fires on the edge where the run length reaches STABLE_CYCLES.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        capture_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (active_s) begin
                    state_d = SETTLE;
                    cnt_d   = 8'd1;
                end else begin
                    cnt_d   = 8'd0;
                end
            end
            SETTLE: begin
                if (!active_s) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end else if (same_s) begin
                    cnt_d   = cnt_q + 8'd1;
                end else begin
                    cnt_d   = 8'd1;
                end
            end
            HELD: begin
                if (same_s) begin
                    state_d = HELD;
                end else if (active_s) begin
                    state_d = SETTLE;
                    cnt_d   = 8'd1;
                end else begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase
        if ((state_d == SETTLE) && (cnt_d == 8'(STABLE_CYCLES))) begin
            capture_s = 1'b1;
            state_d   = HELD;
        end else begin
            capture_s = 1'b0;
        end
    end

    // Capture datapath and frame bookkeeping.
    always_comb begin
        digit_d = digit_q;
        dp_d    = dp_q;
        err_d   = err_q;
        seen_d  = frame_done_s ? 3'b000 : seen_q;
        for (int i = 0; i < 3; i++) begin
            if (capture_s && sel_s[i]) begin
                digit_d[i] = dec_s[3:0];
                dp_d[i]    = dp_low_s;
                err_d[i]   = dec_s[4];
                seen_d[i]  = 1'b1;
            end else begin
                digit_d[i] = digit_q[i];
            end
        end
        if (frame_done_s) begin
            fv_d = 1'b1;
        end else if (frame_ack) begin
            fv_d = 1'b0;
        end else begin
            fv_d = fv_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            seen_q  <= 3'b000;
            digit_q <= '0;
            dp_q    <= 3'b000;
            err_q   <= 3'b000;
            fv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            seen_q  <= seen_d;
            digit_q <= digit_d;
            dp_q    <= dp_d;
            err_q   <= err_d;
            fv_q    <= fv_d;
        end
    end

`ifdef SEG_SCAN_OVERRUN_EN
    logic ovr_q;

    // Sticky overrun: a new frame lands on a held, unacknowledged one.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ovr_q <= 1'b0;
        end else begin
            ovr_q <= ovr_q | (frame_done_s & fv_q & ~frame_ack);
        end
    end

    assign overrun = ovr_q;
`else
    assign overrun = 1'b0;
`endif

    assign digit0      = digit_q[0];
    assign digit1      = digit_q[1];
    assign digit2      = digit_q[2];
    assign dp_flags    = dp_q;
    assign digit_err   = err_q;
    assign frame_valid = fv_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder (STABLE_CYCLES = 4); overrun expectation follows SEG_SCAN_OVERRUN_EN.
module tb_seg_scan_decoder;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       AN0 = 1'b1, AN1 = 1'b1, AN2 = 1'b1;
    logic       a = 1'b1, b = 1'b1, c = 1'b1, d = 1'b1, e = 1'b1, fp = 1'b1, g = 1'b1;
    logic       dp = 1'b1;
    logic       frame_ack = 1'b0;
    logic [3:0] digit0, digit1, digit2;
    logic [2:0] dp_flags, digit_err;
    logic       frame_valid, overrun;

    int tests_run = 0;
    int tests_failed = 0;

`ifdef SEG_SCAN_OVERRUN_EN
    localparam logic EXP_OVR = 1'b1;
`else
    localparam logic EXP_OVR = 1'b0;
`endif

    typedef struct {
        int         idx;
        logic [3:0] val;
        logic       dpl;
        logic       err;
    } exp_t;

    exp_t sb_q[$];

    seg_scan_decoder #(.STABLE_CYCLES(4)) dut (
        .clock(clock), .reset(reset),
        .AN0(AN0), .AN1(AN1), .AN2(AN2),
        .a(a), .b(b), .c(c), .d(d), .e(e), .fp(fp), .g(g), .dp(dp),
        .frame_ack(frame_ack),
        .digit0(digit0), .digit1(digit1), .digit2(digit2),
        .dp_flags(dp_flags), .digit_err(digit_err),
        .frame_valid(frame_valid), .overrun(overrun)
    );

    always #5 clock = ~clock;

    function automatic logic [3:0] dig_of(input int i);
        case (i)
            0:       return digit0;
            1:       return digit1;
            default: return digit2;
        endcase
    endfunction

    // Entry layout: {digitN, dp_flags[N], digit_err[N]} observed versus expected.
    function automatic logic [5:0] obs_of(input int i);
        return {dig_of(i), dp_flags[i], digit_err[i]};
    endfunction

    task automatic drive(input int idx, input logic [6:0] pat, input logic dpl);
        logic [2:0] an;
        an = ~(3'b001 << idx);
        @(negedge clock);
        {AN2, AN1, AN0} = an;
        {a, b, c, d, e, fp, g} = ~pat;
        dp = ~dpl;
    endtask

    task automatic drive_raw(input logic [2:0] an, input logic [6:0] pat);
        @(negedge clock);
        {AN2, AN1, AN0} = an;
        {a, b, c, d, e, fp, g} = ~pat;
        dp = 1'b1;
    endtask

    task automatic sb_push(input int idx, input logic [3:0] val, input logic dpl, input logic err);
        exp_t x;
        x.idx = idx; x.val = val; x.dpl = dpl; x.err = err;
        sb_q.push_back(x);
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1;
        frame_ack = 1'b0;
        {AN2, AN1, AN0} = 3'b111;
        {a, b, c, d, e, fp, g} = 7'h7F;
        dp = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        tests_run++;
        if ({digit2, digit1, digit0} !== 12'h000) begin
            tests_failed++;
            $display("FAIL reset_digits: got %h expected 000", {digit2, digit1, digit0});
        end
        tests_run++;
        if ({dp_flags, digit_err} !== 6'b000000) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b expected 000000", {dp_flags, digit_err});
        end
        tests_run++;
        if ({frame_valid, overrun} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_frame: got %b expected 00", {frame_valid, overrun});
        end
    endtask

    task automatic test_latency();
        apply_reset();
        drive(0, 7'h30, 1'b0);
        wait_edges(5);
        tests_run++;
        if (digit0 !== 4'h0) begin
            tests_failed++;
            $display("FAIL latency_edge5: got %h expected 0", digit0);
        end
        wait_edges(1);
        tests_run++;
        if (digit0 !== 4'h1) begin
            tests_failed++;
            $display("FAIL latency_edge6: got %h expected 1", digit0);
        end
    endtask

    task automatic test_frame();
        logic [6:0] pats [3];
        logic [3:0] vals [3];
        exp_t x;
        pats = '{7'h79, 7'h7E, 7'h47};
        vals = '{4'h3, 4'h0, 4'hF};
        apply_reset();
        @(negedge clock);
        frame_ack = 1'b1;
        @(negedge clock);
        frame_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(i, pats[i], (i == 1));
            sb_push(i, vals[i], (i == 1), 1'b0);
            wait_edges(10);
            x = sb_q.pop_front();
            tests_run++;
            if (obs_of(x.idx) !== {x.val, x.dpl, x.err}) begin
                tests_failed++;
                $display("FAIL frame_digit%0d: got %h expected %h", x.idx, obs_of(x.idx), {x.val, x.dpl, x.err});
            end
        end
        tests_run++;
        if ({frame_valid, dp_flags, digit2, digit1, digit0} !== {1'b1, 3'b010, 12'hF03}) begin
            tests_failed++;
            $display("FAIL frame_complete: got fv=%b dp=%b digits=%h expected fv=1 dp=010 digits=f03",
                     frame_valid, dp_flags, {digit2, digit1, digit0});
        end
        @(negedge clock);
        frame_ack = 1'b1;
        @(negedge clock);
        frame_ack = 1'b0;
        #1;
        tests_run++;
        if (frame_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL frame_ack_clear: got %b expected 0", frame_valid);
        end
    endtask

    task automatic test_decode();
        logic [6:0] tbl [16];
        exp_t x;
        tbl = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
        apply_reset();
        drive(2, 7'h01, 1'b0);
        sb_push(2, 4'h0, 1'b0, 1'b1);
        wait_edges(8);
        x = sb_q.pop_front();
        tests_run++;
        if ({obs_of(x.idx), digit_err} !== {x.val, x.dpl, x.err, 3'b100}) begin
            tests_failed++;
            $display("FAIL decode_err: got %h err=%b expected %h err=100", obs_of(x.idx), digit_err, {x.val, x.dpl, x.err});
        end
        drive(2, 7'h5B, 1'b0);
        sb_push(2, 4'h5, 1'b0, 1'b0);
        wait_edges(8);
        x = sb_q.pop_front();
        tests_run++;
        if ({obs_of(x.idx), digit_err} !== {x.val, x.dpl, x.err, 3'b000}) begin
            tests_failed++;
            $display("FAIL decode_err_clear: got %h err=%b expected %h err=000", obs_of(x.idx), digit_err, {x.val, x.dpl, x.err});
        end
        for (int i = 0; i < 16; i++) begin
            drive(0, tbl[i], i[0]);
            sb_push(0, 4'(i), i[0], 1'b0);
            wait_edges(8);
            x = sb_q.pop_front();
            tests_run++;
            if (obs_of(x.idx) !== {x.val, x.dpl, x.err}) begin
                tests_failed++;
                $display("FAIL decode_table_%0d: got %h expected %h", i, obs_of(x.idx), {x.val, x.dpl, x.err});
            end
        end
    endtask

    task automatic test_short_hold();
        exp_t x;
        apply_reset();
        drive(0, 7'h30, 1'b0);
        repeat (3) @(posedge clock);
        drive_raw(3'b100, 7'h30);
        wait_edges(10);
        tests_run++;
        if (digit0 !== 4'h0) begin
            tests_failed++;
            $display("FAIL short_hold_digit0: got %h expected 0", digit0);
        end
        for (int i = 1; i < 3; i++) begin
            drive(i, 7'h30, 1'b0);
            sb_push(i, 4'h1, 1'b0, 1'b0);
            wait_edges(10);
            x = sb_q.pop_front();
            tests_run++;
            if (obs_of(x.idx) !== {x.val, x.dpl, x.err}) begin
                tests_failed++;
                $display("FAIL short_hold_digit%0d: got %h expected %h", x.idx, obs_of(x.idx), {x.val, x.dpl, x.err});
            end
        end
        tests_run++;
        if (frame_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL short_hold_no_frame: got %b expected 0", frame_valid);
        end
        drive(0, 7'h30, 1'b0);
        wait_edges(10);
        tests_run++;
        if (frame_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL short_hold_late_frame: got %b expected 1", frame_valid);
        end
    endtask

    task automatic test_overrun();
        logic [6:0] pats [3];
        exp_t x;
        pats = '{7'h30, 7'h6D, 7'h79};
        for (int pass = 0; pass < 2; pass++) begin
            apply_reset();
            for (int f = 0; f < 2; f++) begin
                for (int i = 0; i < 3; i++) begin
                    drive(i, pats[i], 1'b0);
                    sb_push(i, 4'(i + 1), 1'b0, 1'b0);
                    if (pass == 1 && f == 1 && i == 2) begin
                        repeat (6) @(posedge clock);
                        @(negedge clock);
                        frame_ack = 1'b1;
                        @(negedge clock);
                        frame_ack = 1'b0;
                        wait_edges(3);
                    end else begin
                        wait_edges(10);
                    end
                    x = sb_q.pop_front();
                    tests_run++;
                    if (obs_of(x.idx) !== {x.val, x.dpl, x.err}) begin
                        tests_failed++;
                        $display("FAIL overrun_digit p%0d f%0d d%0d: got %h expected %h",
                                 pass, f, x.idx, obs_of(x.idx), {x.val, x.dpl, x.err});
                    end
                end
            end
            tests_run++;
            if ({frame_valid, overrun} !== {1'b1, (pass == 0) ? EXP_OVR : 1'b0}) begin
                tests_failed++;
                $display("FAIL overrun_p%0d: got fv=%b ovr=%b expected fv=1 ovr=%b",
                         pass, frame_valid, overrun, (pass == 0) ? EXP_OVR : 1'b0);
            end
        end
    endtask

    task automatic test_reset_mid_settle();
        exp_t x;
        apply_reset();
        drive(0, 7'h30, 1'b1);
        wait_edges(8);
        drive(1, 7'h79, 1'b0);
        repeat (4) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        tests_run++;
        if ({digit2, digit1, digit0, dp_flags, digit_err, frame_valid, overrun} !== 20'h00000) begin
            tests_failed++;
            $display("FAIL midsettle_async_reset: got %h expected 00000",
                     {digit2, digit1, digit0, dp_flags, digit_err, frame_valid, overrun});
        end
        @(negedge clock);
        reset = 1'b0;
        sb_push(1, 4'h3, 1'b0, 1'b0);
        wait_edges(5);
        tests_run++;
        if (digit1 !== 4'h0) begin
            tests_failed++;
            $display("FAIL midsettle_edge5: got %h expected 0", digit1);
        end
        wait_edges(1);
        x = sb_q.pop_front();
        tests_run++;
        if (obs_of(x.idx) !== {x.val, x.dpl, x.err}) begin
            tests_failed++;
            $display("FAIL midsettle_edge6: got %h expected %h", obs_of(x.idx), {x.val, x.dpl, x.err});
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_frame();
        test_decode();
        test_short_hold();
        test_overrun();
        test_reset_mid_settle();
        tests_run++;
        if (sb_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
